// File: rtl/regfile_2w_sb.sv
// Two-write/two-read register file with HI/LO pair and a load-use pending scoreboard.
// Reads and HI/LO are combinational with same-cycle write-through; stall flags reads of pending loads.
module regfile_2w_sb #(
  parameter int                 DATA_W  = 32,
  parameter int                 ADDR_W  = 5,
  parameter int                 SP_IDX  = 29,
  parameter logic [DATA_W-1:0]  SP_INIT = 'h2ffc,
  parameter int                 GP_IDX  = 28,
  parameter logic [DATA_W-1:0]  GP_INIT = 'h1800
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] data_r_1,
  output logic [DATA_W-1:0] data_r_2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] rd0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] rd1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              hilo_we,
  input  logic [DATA_W-1:0] hi_w,
  input  logic [DATA_W-1:0] lo_w,
  output logic [DATA_W-1:0] hi_r,
  output logic [DATA_W-1:0] lo_r,
  input  logic              pend_en,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              stall
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_pend;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      localparam logic [DATA_W-1:0] RST_VAL = (gi == SP_IDX) ? SP_INIT :
                                              (gi == GP_IDX) ? GP_INIT : '0;
      if (gi == 0) begin : g_zero
        assign r_regs[gi] = '0;
        assign r_pend[gi] = 1'b0;
      end else begin : g_live
        // Load writeback (port 1) is the younger result, so it takes priority.
        always_ff @(posedge CLK) begin
          if (RST) begin
            r_regs[gi] <= RST_VAL;
          end else if (we1 && (rd1 == IDX)) begin
            r_regs[gi] <= wdata1;
          end else if (we0 && (rd0 == IDX)) begin
            r_regs[gi] <= wdata0;
          end
        end

        // A newly issued load outranks the writeback of the previous one.
        always_ff @(posedge CLK) begin
          if (RST) begin
            r_pend[gi] <= 1'b0;
          end else if (pend_en && (pend_addr == IDX)) begin
            r_pend[gi] <= 1'b1;
          end else if (we1 && (rd1 == IDX)) begin
            r_pend[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (hilo_we) begin
      r_hi <= hi_w;
      r_lo <= lo_w;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = r_regs[addr];
    if (addr == '0)                  v = '0;
    else if (we1 && (rd1 == addr))   v = wdata1;
    else if (we0 && (rd0 == addr))   v = wdata0;
    return v;
  endfunction

  function automatic logic hit(input logic [ADDR_W-1:0] addr);
    return (addr != '0) && r_pend[addr] && !(we1 && (rd1 == addr));
  endfunction

  logic [DATA_W-1:0] w_rd1_data;
  logic [DATA_W-1:0] w_rd2_data;
  logic              w_stall;

  always_comb begin
    w_rd1_data = read_port(rs1);
    w_rd2_data = read_port(rs2);
    w_stall    = hit(rs1) | hit(rs2);
  end

  always_comb begin
    data_r_1 = '0;
    data_r_2 = '0;
    hi_r     = '0;
    lo_r     = '0;
    stall    = 1'b0;
    if (!RST) begin
      data_r_1 = w_rd1_data;
      data_r_2 = w_rd2_data;
      hi_r     = hilo_we ? hi_w : r_hi;
      lo_r     = hilo_we ? lo_w : r_lo;
      stall    = w_stall;
    end
  end

endmodule

// File: tb/tb_regfile_2w_sb.sv
// Directed bench for regfile_2w_sb: reset values, dual write, bypass, HI/LO, scoreboard stall, reset mid-op.
module tb_regfile_2w_sb;
  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  rs1, rs2, rd0, rd1, pend_addr;
  logic [31:0] data_r_1, data_r_2, wdata0, wdata1, hi_w, lo_w, hi_r, lo_r;
  logic        we0, we1, hilo_we, pend_en, stall;

  int total = 0;
  int bad   = 0;

  regfile_2w_sb dut (
    .CLK(CLK), .RST(RST), .rs1(rs1), .rs2(rs2),
    .data_r_1(data_r_1), .data_r_2(data_r_2),
    .we0(we0), .rd0(rd0), .wdata0(wdata0),
    .we1(we1), .rd1(rd1), .wdata1(wdata1),
    .hilo_we(hilo_we), .hi_w(hi_w), .lo_w(lo_w), .hi_r(hi_r), .lo_r(lo_r),
    .pend_en(pend_en), .pend_addr(pend_addr), .stall(stall)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("t=%0t %s observed=%h expected=%h", $time, tag, obs, exp);
  endtask

  // Advance past the next active edge; outputs are then sampled mid-cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; hilo_we = 0; pend_en = 0;
    rd0 = 0; rd1 = 0; wdata0 = 0; wdata1 = 0; hi_w = 0; lo_w = 0; pend_addr = 0;
  endtask

  initial begin
    idle();
    RST = 1; rs1 = 29; rs2 = 28;
    #1;
    check("rst_hold_rd1", data_r_1, 32'h0);
    check("rst_hold_stall", {31'b0, stall}, 32'h0);
    tick();
    RST = 0;
    #1;
    check("rst_sp", data_r_1, 32'h2ffc);
    check("rst_gp", data_r_2, 32'h1800);
    rs1 = 5; #1;
    check("rst_r5", data_r_1, 32'h0);
    check("rst_hi", hi_r, 32'h0);
    check("rst_lo", lo_r, 32'h0);

    // dual write, distinct addresses
    we0 = 1; rd0 = 3; wdata0 = 32'h11; we1 = 1; rd1 = 4; wdata1 = 32'h22;
    tick(); idle();
    rs1 = 3; rs2 = 4; #1;
    check("dual_r3", data_r_1, 32'h11);
    check("dual_r4", data_r_2, 32'h22);
    // collision: load port wins
    we0 = 1; rd0 = 7; wdata0 = 32'hAA; we1 = 1; rd1 = 7; wdata1 = 32'hBB;
    tick(); idle();
    rs1 = 7; #1;
    check("collide_r7", data_r_1, 32'hBB);
    // writes to r0 dropped, also during bypass
    we0 = 1; rd0 = 0; wdata0 = 32'hFFFF; we1 = 1; rd1 = 0; wdata1 = 32'hFFFF; rs1 = 0; #1;
    check("r0_bypass", data_r_1, 32'h0);
    tick(); idle(); #1;
    check("r0_stored", data_r_1, 32'h0);

    // same-cycle write-through
    we1 = 1; rd1 = 9; wdata1 = 32'h1234; rs1 = 9; #1;
    check("byp_we1", data_r_1, 32'h1234);
    tick(); idle(); #1;
    check("byp_stored", data_r_1, 32'h1234);
    we0 = 1; rd0 = 9; wdata0 = 32'h5; we1 = 1; rd1 = 9; wdata1 = 32'h6; rs2 = 9; #1;
    check("byp_both_p1", data_r_1, 32'h6);
    check("byp_both_p2", data_r_2, 32'h6);
    tick(); idle();
    we0 = 1; rd0 = 11; wdata0 = 32'h77; rs1 = 11; #1;
    check("byp_we0", data_r_1, 32'h77);
    tick(); idle();

    // HI/LO
    hilo_we = 1; hi_w = 32'hCAFE0001; lo_w = 32'hBEEF0002; #1;
    check("hi_bypass", hi_r, 32'hCAFE0001);
    check("lo_bypass", lo_r, 32'hBEEF0002);
    tick(); idle(); #1;
    check("hi_stored", hi_r, 32'hCAFE0001);
    check("lo_stored", lo_r, 32'hBEEF0002);

    // load-use stall
    rs1 = 0; rs2 = 0;
    pend_en = 1; pend_addr = 8;
    tick(); idle();
    rs2 = 8; #1;
    check("lu_stall_c0", {31'b0, stall}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lu_stall_hold", {31'b0, stall}, 32'h1);
    end
    we1 = 1; rd1 = 8; wdata1 = 32'h55; #1;
    check("lu_resolve_stall", {31'b0, stall}, 32'h0);
    check("lu_resolve_data", data_r_2, 32'h55);
    tick(); idle(); #1;
    check("lu_after_stall", {31'b0, stall}, 32'h0);
    check("lu_after_data", data_r_2, 32'h55);
    // we0 never clears pending; stall via rs1 as well
    rs2 = 0;
    pend_en = 1; pend_addr = 12;
    tick(); idle();
    we0 = 1; rd0 = 12; wdata0 = 32'h3;
    tick(); idle();
    rs1 = 12; #1;
    check("we0_noclear", {31'b0, stall}, 32'h1);
    we1 = 1; rd1 = 12; wdata1 = 32'h4;
    tick(); idle(); #1;
    check("we1_clear", {31'b0, stall}, 32'h0);

    // simultaneous set and clear: set wins, data still written
    rs1 = 0;
    pend_en = 1; pend_addr = 6;
    tick(); idle();
    pend_en = 1; pend_addr = 6; we1 = 1; rd1 = 6; wdata1 = 32'h66; rs1 = 6; #1;
    check("setclr_same_cycle", {31'b0, stall}, 32'h0);
    tick(); idle(); #1;
    check("setclr_pend_kept", {31'b0, stall}, 32'h1);
    check("setclr_r6", data_r_1, 32'h66);
    we1 = 1; rd1 = 6; wdata1 = 32'h67;
    tick(); idle();
    pend_en = 1; pend_addr = 0; rs1 = 0; #1;
    check("pend0_now", {31'b0, stall}, 32'h0);
    tick(); idle(); #1;
    check("pend0_after", {31'b0, stall}, 32'h0);

    // reset mid-operation
    pend_en = 1; pend_addr = 10; hilo_we = 1; hi_w = 32'h12; lo_w = 32'h34;
    tick(); idle();
    rs1 = 10; rs2 = 29; #1;
    check("mid_pend_set", {31'b0, stall}, 32'h1);
    check("mid_hi_set", hi_r, 32'h12);
    RST = 1; we0 = 1; rd0 = 10; wdata0 = 32'h99; pend_en = 1; pend_addr = 10; #1;
    check("mid_rst_rd", data_r_1, 32'h0);
    check("mid_rst_stall", {31'b0, stall}, 32'h0);
    tick(); idle();
    RST = 0; #1;
    check("mid_r10", data_r_1, 32'h0);
    check("mid_stall", {31'b0, stall}, 32'h0);
    check("mid_sp", data_r_2, 32'h2ffc);
    check("mid_hi", hi_r, 32'h0);
    check("mid_lo", lo_r, 32'h0);
    rs1 = 7; #1;
    check("mid_r7_cleared", data_r_1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
